// File: rtl/pep9_mem_pkg.sv
// Shared widths and FSM state type for the Pep9 memory-port arbiter.
package pep9_mem_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request scanning upward from ptr_i+1,
// wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               any_o
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    sum         = '0;
    cand        = '0;
    // ptr_i < NUM_REQ and offset <= NUM_REQ, so one conditional subtract is a full modulo
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      sum = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/apb_mem_arbiter.sv
// Round-robin arbiter sharing the apb_top memory port between NUM_REQ Pep9 requesters.
// Define ARB_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES cycles with err_o set.
module apb_mem_arbiter
  import pep9_mem_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                            sysclk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ-1:0]              we_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  addr_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  wdata_i,
  output logic [NUM_REQ-1:0]              ack_o,
  output logic [DATA_W-1:0]               rdata_o,
  output logic                            err_o,
  output logic                            busy_o,
  output logic [ADDR_W-1:0]               address,
  output logic [DATA_W-1:0]               writeData,
  output logic                            we,
  output logic                            mem_req,
  input  logic [DATA_W-1:0]               readData,
  input  logic                            done
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [NUM_REQ-1:0] goh_q, goh_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               we_q, we_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               expired;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i       (req_i),
    .ptr_i       (ptr_q),
    .grant_o     (pick_oh),
    .grant_idx_o (pick_idx),
    .any_o       (pick_any)
  );

`ifdef ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  // Zero outside WAIT, so it is already clear on every WAIT entry
  always_comb begin
    tmo_cnt_d = (state_q == WAIT) ? tmo_cnt_q + 16'd1 : 16'd0;
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= 16'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign expired = (state_q == WAIT) && (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expired        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    goh_d   = goh_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gidx_d  = pick_idx;
          goh_d   = pick_oh;
          addr_d  = addr_i[pick_idx];
          wdata_d = wdata_i[pick_idx];
          we_d    = we_i[pick_idx];
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // done wins over a coincident expiry
        if (done) begin
          rdata_d = readData;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        ptr_d   = gidx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      goh_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      goh_q   <= goh_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    ack_o   = (state_q == RESP) ? goh_q : '0;
    busy_o  = (state_q != IDLE);
    mem_req = (state_q == ISSUE) || (state_q == WAIT);
  end

  assign address   = addr_q;
  assign writeData = wdata_q;
  assign we        = we_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;

endmodule
